// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the TX scheduler, its FWFT TX FIFO and the UART
// transmitter. The master side is the scheduler; the slave side is the FIFO
// plus transmitter pair.
interface uart_tx_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_fifo_empty;
    logic [DATA_WIDTH-1:0] i_fifo_rd_data;
    logic                  o_fifo_rd_en;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_start;
    logic                  i_tx_busy;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_rd_data,
        input  i_tx_busy,
        output o_fifo_rd_en,
        output o_tx_data,
        output o_tx_start
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_rd_data,
        output i_tx_busy,
        input  o_fifo_rd_en,
        input  o_tx_data,
        input  o_tx_start
    );
endinterface

// File: rtl/uart_tx_sched.sv
// UART TX scheduler: pops bytes from an FWFT FIFO, hands each one to the
// transmitter with a start pulse, waits for the frame to finish, inserts a
// programmable idle gap, and can discard the FIFO contents on request.
module uart_tx_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int TO_CYCLES  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_enable,
    input  logic                 i_flush,
    input  logic [GAP_WIDTH-1:0] i_gap_cycles,
    uart_tx_sched_if.master      bus,
    output logic                 o_busy,
    output logic [15:0]          o_frame_cnt,
    output logic                 o_err
);
    // Ack counter only has to count 0 .. TO_CYCLES-1.
    localparam int ACK_W = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        FLUSH
    } state_t;

    state_t                state_q,      state_d;
    logic [DATA_WIDTH-1:0] tx_data_q,    tx_data_d;
    logic [15:0]           frame_cnt_q,  frame_cnt_d;
    logic                  err_q,        err_d;
    logic [GAP_WIDTH-1:0]  gap_q,        gap_d;
    logic [ACK_W-1:0]      ack_q,        ack_d;
    logic                  flush_pend_q, flush_pend_d;

    // State register and datapath flops, cleared asynchronously.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tx_data_q    <= '0;
            frame_cnt_q  <= '0;
            err_q        <= 1'b0;
            gap_q        <= '0;
            ack_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
            gap_q        <= gap_d;
            ack_q        <= ack_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Next-state and next-datapath decode for the frame scheduler.
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        frame_cnt_d  = frame_cnt_q;
        err_d        = err_q;
        gap_d        = gap_q;
        ack_d        = ack_q;
        // A flush pulse arriving mid-frame is remembered until the next IDLE.
        flush_pend_d = flush_pend_q | i_flush;

        case (state_q)
            IDLE: begin
                if (i_flush || flush_pend_q) begin
                    state_d = FLUSH;
                end else if (i_enable && !bus.i_fifo_empty && !bus.i_tx_busy) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_data_d = bus.i_fifo_rd_data;
                state_d   = START;
            end
            START: begin
                ack_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (bus.i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_q == ACK_W'(TO_CYCLES - 1)) begin
                    // Transmitter never answered: the byte is dropped, not counted.
                    err_d   = 1'b1;
                    gap_d   = i_gap_cycles;
                    state_d = GAP;
                end else begin
                    ack_d = ack_q + ACK_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.i_tx_busy) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    gap_d       = i_gap_cycles;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_WIDTH'(1);
                end
            end
            FLUSH: begin
                if (bus.i_fifo_empty) begin
                    flush_pend_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pop is decoded from state so it can never fire against an empty FIFO.
    assign bus.o_fifo_rd_en = (state_q == LOAD) || ((state_q == FLUSH) && !bus.i_fifo_empty);
    assign bus.o_tx_start   = (state_q == START);
    assign bus.o_tx_data    = tx_data_q;
    assign o_busy           = (state_q != IDLE);
    assign o_frame_cnt      = frame_cnt_q;
    assign o_err            = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: FWFT FIFO model, transmitter model that
// holds busy for a fixed number of cycles, and event logs with cycle stamps.
module tb_uart_tx_sched;
    localparam int BUSY_LEN = 10;
    localparam int TO_CYC   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_enable = 1'b0;
    logic       i_flush = 1'b0;
    logic [7:0] i_gap_cycles = 8'd0;
    logic       o_busy;
    logic [15:0] o_frame_cnt;
    logic       o_err;

    uart_tx_sched_if #(.DATA_WIDTH(8)) bus();

    uart_tx_sched #(.DATA_WIDTH(8), .GAP_WIDTH(8), .TO_CYCLES(TO_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_enable     (i_enable),
        .i_flush      (i_flush),
        .i_gap_cycles (i_gap_cycles),
        .bus          (bus),
        .o_busy       (o_busy),
        .o_frame_cnt  (o_frame_cnt),
        .o_err        (o_err)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: pushes from the stimulus, pops from the DUT.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.i_fifo_empty   = (rd_ptr == wr_ptr);
    assign bus.i_fifo_rd_data = mem[rd_ptr % 64];
    always @(posedge clk) if (bus.o_fifo_rd_en && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;

    // Transmitter model: busy for BUSY_LEN cycles after a start, unless told to ignore it.
    logic never_ack = 1'b0;
    int   busy_cnt = 0;
    assign bus.i_tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (bus.o_tx_start && !never_ack) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0)           busy_cnt <= busy_cnt - 1;
    end

    // Event logs stamped with the cycle number.
    int   cyc = 0;
    int   rd_n = 0, st_n = 0, fall_n = 0;
    int   rd_cyc [0:255];
    int   st_cyc [0:255];
    int   fall_cyc [0:255];
    logic [7:0] st_data [0:255];
    logic busy_prev = 1'b0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        busy_prev <= bus.i_tx_busy;
        if (bus.o_fifo_rd_en) begin
            rd_cyc[rd_n % 256] <= cyc;
            rd_n <= rd_n + 1;
        end
        if (bus.o_tx_start) begin
            st_cyc[st_n % 256]  <= cyc;
            st_data[st_n % 256] <= bus.o_tx_data;
            st_n <= st_n + 1;
        end
        if (busy_prev && !bus.i_tx_busy) begin
            fall_cyc[fall_n % 256] <= cyc;
            fall_n <= fall_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 64] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits until FIFO drained, scheduler idle and transmitter quiet.
    task automatic wait_idle(input int max_cycles, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.i_fifo_empty && !o_busy && !bus.i_tx_busy) && n < max_cycles);
        check(tag, 32'(n < max_cycles), 32'd1);
    endtask

    // Returns on the negedge during which the start pulse is high.
    task automatic wait_start(input int max_cycles, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_tx_start && n < max_cycles);
        check(tag, 32'(n < max_cycles), 32'd1);
    endtask

    int r0, s0, f0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",     32'(o_busy), 32'd0);
        check("rst_frame",    32'(o_frame_cnt), 32'd0);
        check("rst_err",      32'(o_err), 32'd0);
        check("rst_tx_data",  32'(bus.o_tx_data), 32'd0);
        check("rst_tx_start", 32'(bus.o_tx_start), 32'd0);
        check("rst_rd_en",    32'(bus.o_fifo_rd_en), 32'd0);
        rst_n = 1'b1;

        // Single byte 0xAA, gap 0
        i_enable = 1'b1;
        i_gap_cycles = 8'd0;
        @(negedge clk);
        r0 = rd_n; s0 = st_n;
        push(8'hAA);
        wait_idle(60, "t1_timeout");
        check("t1_pops",     32'(rd_n - r0), 32'd1);
        check("t1_starts",   32'(st_n - s0), 32'd1);
        check("t1_latency",  32'(st_cyc[s0] - rd_cyc[r0]), 32'd1);
        check("t1_data",     32'(st_data[s0]), 32'hAA);
        check("t1_frame",    32'(o_frame_cnt), 32'd1);
        check("t1_idle",     32'(o_busy), 32'd0);
        check("t1_hold",     32'(bus.o_tx_data), 32'hAA);

        // Three bytes with gap 5: busy fall -> WAIT_DONE, 6 GAP cycles, IDLE, LOAD = 8 cycles
        do_reset();
        i_gap_cycles = 8'd5;
        r0 = rd_n; s0 = st_n; f0 = fall_n;
        push(8'h11); push(8'h22); push(8'h33);
        wait_idle(200, "t2_timeout");
        check("t2_starts", 32'(st_n - s0), 32'd3);
        check("t2_data0",  32'(st_data[s0]),     32'h11);
        check("t2_data1",  32'(st_data[s0 + 1]), 32'h22);
        check("t2_data2",  32'(st_data[s0 + 2]), 32'h33);
        check("t2_frame",  32'(o_frame_cnt), 32'd3);
        check("t2_space1", 32'(rd_cyc[r0 + 1] - fall_cyc[f0]),     32'd8);
        check("t2_space2", 32'(rd_cyc[r0 + 2] - fall_cyc[f0 + 1]), 32'd8);

        // Acknowledge timeout, then a normal byte
        do_reset();
        i_gap_cycles = 8'd0;
        never_ack = 1'b1;
        push(8'h5A);
        wait_start(20, "t3_start");
        repeat (TO_CYC) @(negedge clk);
        check("t3_err_before", 32'(o_err), 32'd0);
        @(negedge clk);
        check("t3_err_set",    32'(o_err), 32'd1);
        wait_idle(40, "t3_timeout");
        check("t3_frame0",     32'(o_frame_cnt), 32'd0);
        never_ack = 1'b0;
        s0 = st_n;
        push(8'h5B);
        wait_idle(60, "t3_timeout2");
        check("t3_next_data",  32'(st_data[s0]), 32'h5B);
        check("t3_frame1",     32'(o_frame_cnt), 32'd1);
        check("t3_err_sticky", 32'(o_err), 32'd1);

        // Asynchronous reset mid-WAIT_DONE
        push(8'h3C);
        wait_start(20, "t4_start");
        repeat (3) @(negedge clk);
        check("t4_busy_pre", 32'(o_busy), 32'd1);
        check("t4_data_pre", 32'(bus.o_tx_data), 32'h3C);
        #2 rst_n = 1'b0;
        #1;
        check("t4_busy",  32'(o_busy), 32'd0);
        check("t4_data",  32'(bus.o_tx_data), 32'd0);
        check("t4_frame", 32'(o_frame_cnt), 32'd0);
        check("t4_err",   32'(o_err), 32'd0);
        check("t4_start", 32'(bus.o_tx_start), 32'd0);
        check("t4_rd_en", 32'(bus.o_fifo_rd_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

        // Flush pulsed during frame 1 of 16
        do_reset();
        r0 = rd_n; s0 = st_n;
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        wait_start(20, "t5_start");
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        wait_idle(300, "t5_timeout");
        check("t5_starts", 32'(st_n - s0), 32'd1);
        check("t5_frame",  32'(o_frame_cnt), 32'd1);
        check("t5_pops",   32'(rd_n - r0), 32'd16);
        check("t5_burst",  32'(rd_cyc[r0 + 15] - rd_cyc[r0 + 1]), 32'd14);
        check("t5_empty",  32'(bus.i_fifo_empty), 32'd1);

        // Frame counter wrap
        do_reset();
        @(negedge clk);
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        check("t6_preset", 32'(o_frame_cnt), 32'hFFFF);
        s0 = st_n;
        push(8'h77);
        wait_idle(60, "t6_timeout");
        check("t6_wrap", 32'(o_frame_cnt), 32'd0);
        check("t6_data", 32'(st_data[s0]), 32'h77);

        // Enable dropped during WAIT_DONE
        do_reset();
        r0 = rd_n; s0 = st_n;
        push(8'h01); push(8'h02); push(8'h03);
        wait_start(20, "t7_start");
        repeat (3) @(negedge clk);
        i_enable = 1'b0;
        repeat (40) @(negedge clk);
        check("t7_starts", 32'(st_n - s0), 32'd1);
        check("t7_pops",   32'(rd_n - r0), 32'd1);
        check("t7_frame",  32'(o_frame_cnt), 32'd1);
        check("t7_idle",   32'(o_busy), 32'd0);
        check("t7_left",   32'(bus.i_fifo_empty), 32'd0);
        i_enable = 1'b1;
        wait_idle(200, "t7_timeout");
        check("t7_drain",  32'(o_frame_cnt), 32'd3);
        check("t7_last",   32'(st_data[s0 + 2]), 32'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
